rd_cmd_issue: RTL and testbench

//  Downstream of the DSO read address generator: accepts 28-bit DDR read addresses and their one-cycle

---
 rtl/rd_cmd_pkg.sv | 21 ++
 rtl/rd_addr_fifo.sv | 48 ++++
 rtl/rd_cmd_issue.sv | 148 ++++++++++++++
 tb/tb_rd_cmd_issue.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rd_cmd_pkg.sv
// Shared definitions for the read-command issue block: MIG command codes, default widths, FSM states.
// Latency: none (package only).
// Backpressure: none (package only).
package rd_cmd_pkg;

    localparam logic [2:0] MIG_CMD_READ  = 3'b001;
    localparam logic [2:0] MIG_CMD_WRITE = 3'b000;

    localparam int ADDR_W_DEF    = 28;
    localparam int FIFO_AW_DEF   = 4;
    localparam int MAX_OUTST_DEF = 32;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_DRAIN = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DONE  = 3'd4
    } rd_state_e;

endpackage

// File: rtl/rd_addr_fifo.sv
// Show-ahead address FIFO, W x 2^AW; dout is the head, dout_nxt the entry behind it.
// Latency: a write becomes visible at the head one cycle after wr_en.
// Backpressure: caller must not write when full unless it pops in the same cycle.
module rd_addr_fifo #(
    parameter int W  = 28,
    parameter int AW = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_en,
    input  logic         rd_en,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic [W-1:0] dout_nxt,
    output logic         full,
    output logic         empty,
    output logic [AW:0]  level
);

    logic [W-1:0]  mem [0:(1<<AW)-1];
    logic [AW:0]   wptr;
    logic [AW:0]   rptr;
    logic [AW-1:0] rnxt;

    // Pointer update; the extra MSB distinguishes full from empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wr_en) wptr <= wptr + {{AW{1'b0}}, 1'b1};
            if (rd_en) rptr <= rptr + {{AW{1'b0}}, 1'b1};
        end
    end

    // Storage array; contents need no reset because the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wptr[AW-1:0]] <= din;
    end

    assign rnxt     = rptr[AW-1:0] + {{(AW-1){1'b0}}, 1'b1};
    assign dout     = mem[rptr[AW-1:0]];
    assign dout_nxt = mem[rnxt];
    assign level    = wptr - rptr;
    assign empty    = (wptr == rptr);
    assign full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

endmodule

// File: rtl/rd_cmd_issue.sv
// Buffers read addresses and issues MIG READ commands, bounding in-flight reads; optional stats via RD_CMD_STAT_EN.
// Latency: addr_vld into an empty FIFO in cycle N gives app_en with that address in cycle N+2; 1 cmd/clk sustained.
// Backpressure: app_en/app_addr hold until app_rdy; addresses arriving while the FIFO is full are dropped and flagged.
module rd_cmd_issue
    import rd_cmd_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int FIFO_AW   = FIFO_AW_DEF,
    parameter int MAX_OUTST = MAX_OUTST_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic              addr_vld,
    input  logic              read_stop,
    output logic [ADDR_W-1:0] app_addr,
    output logic [2:0]        app_cmd,
    output logic              app_en,
    input  logic              app_rdy,
    input  logic              app_rd_data_end,
    output logic              fifo_full,
    output logic [5:0]        outst_cnt,
    output logic              rd_busy,
    output logic              rd_done,
    output logic              ovf_err
`ifdef RD_CMD_STAT_EN
    ,
    output logic [31:0]       stat_cmd_cnt,
    output logic [31:0]       stat_stall_cnt
`endif
);

    rd_state_e         state;
    rd_state_e         state_nxt;
    logic              accept;
    logic              launch;
    logic              fifo_wr;
    logic              fifo_empty;
    logic              cnt_inc;
    logic              cnt_dec;
    logic [ADDR_W-1:0] fifo_dout;
    logic [ADDR_W-1:0] fifo_dout_nxt;
    logic [FIFO_AW:0]  fifo_level;
    logic [6:0]        outst_eff;

    assign app_cmd = MIG_CMD_READ;
    assign accept  = app_en && app_rdy;
    // A full FIFO still takes a write when the head leaves in the same cycle.
    assign fifo_wr = addr_vld && (!fifo_full || accept);

    // The head entry stays in the FIFO until the MIG accepts it, so a stalled
    // command occupies a FIFO slot; on acceptance the entry behind it is next.
    assign outst_eff = {1'b0, outst_cnt} + {6'd0, accept};
    assign launch    = (accept ? (fifo_level > {{FIFO_AW{1'b0}}, 1'b1}) : !fifo_empty)
                       && (outst_eff < 7'(MAX_OUTST));

    rd_addr_fifo #(
        .W  (ADDR_W),
        .AW (FIFO_AW)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (fifo_wr),
        .rd_en    (accept),
        .din      (addr_in),
        .dout     (fifo_dout),
        .dout_nxt (fifo_dout_nxt),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .level    (fifo_level)
    );

    // Command register: present a new entry only when idle or the current one is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            app_en   <= 1'b0;
            app_addr <= '0;
        end else if (!app_en || accept) begin
            app_en <= launch;
            if (launch) app_addr <= accept ? fifo_dout_nxt : fifo_dout;
        end
    end

    assign cnt_inc = accept;
    assign cnt_dec = app_rd_data_end && (outst_cnt != 6'd0);

    // In-flight counter: accept and return in the same cycle cancel out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outst_cnt <= 6'd0;
        end else if (cnt_inc && !cnt_dec && (outst_cnt < 6'(MAX_OUTST))) begin
            outst_cnt <= outst_cnt + 6'd1;
        end else if (cnt_dec && !cnt_inc) begin
            outst_cnt <= outst_cnt - 6'd1;
        end
    end

    // Sticky overflow flag for addresses dropped at a full FIFO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                 ovf_err <= 1'b0;
        else if (addr_vld && fifo_full && !accept) ovf_err <= 1'b1;
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // FSM next state; a new address in WAIT/DONE starts a fresh acquisition.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (fifo_wr) state_nxt = ST_ISSUE;
            ST_ISSUE: if (read_stop) state_nxt = ST_DRAIN;
            ST_DRAIN: if (fifo_empty && !app_en && !fifo_wr) state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (fifo_wr)                 state_nxt = ST_ISSUE;
                else if (outst_cnt == 6'd0)  state_nxt = ST_DONE;
            end
            ST_DONE:  state_nxt = fifo_wr ? ST_ISSUE : ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs decoded from the current state.
    always_comb begin
        rd_busy = (state != ST_IDLE);
        rd_done = (state == ST_DONE);
    end

`ifdef RD_CMD_STAT_EN
    // Per-acquisition statistics, cleared when an acquisition starts from IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_cmd_cnt   <= 32'd0;
            stat_stall_cnt <= 32'd0;
        end else if ((state == ST_IDLE) && (state_nxt != ST_IDLE)) begin
            stat_cmd_cnt   <= 32'd0;
            stat_stall_cnt <= 32'd0;
        end else begin
            if (accept)             stat_cmd_cnt   <= stat_cmd_cnt + 32'd1;
            if (app_en && !app_rdy) stat_stall_cnt <= stat_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_rd_cmd_issue.sv
// Scoreboard bench for rd_cmd_issue: directed scenarios plus randomized acquisitions.
// Latency: checks the N+2 issue latency and 1 cmd/clk back-to-back issue.
// Backpressure: drives app_rdy stalls, overflow, outstanding cap and mid-operation reset.
module tb_rd_cmd_issue;

    localparam int AW = 28;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] addr_in = '0;
    logic          addr_vld = 1'b0;
    logic          read_stop = 1'b0;
    logic          app_rdy = 1'b0;
    logic          app_rd_data_end = 1'b0;
    logic [AW-1:0] app_addr;
    logic [2:0]    app_cmd;
    logic          app_en;
    logic          fifo_full;
    logic [5:0]    outst_cnt;
    logic          rd_busy;
    logic          rd_done;
    logic          ovf_err;
`ifdef RD_CMD_STAT_EN
    logic [31:0]   stat_cmd_cnt;
    logic [31:0]   stat_stall_cnt;
`endif

    int            n_checks = 0;
    int            n_fail = 0;
    int            model_outst = 0;
    int            acc_cnt = 0;
    int            done_cnt = 0;
    bit            rand_mode = 1'b0;
    logic [AW-1:0] sb [$];
    logic          hold_pending = 1'b0;
    logic [AW-1:0] hold_addr = '0;
    logic [AW-1:0] exp_addr;

    rd_cmd_issue dut (
        .clk             (clk),
        .rst             (rst),
        .addr_in         (addr_in),
        .addr_vld        (addr_vld),
        .read_stop       (read_stop),
        .app_addr        (app_addr),
        .app_cmd         (app_cmd),
        .app_en          (app_en),
        .app_rdy         (app_rdy),
        .app_rd_data_end (app_rd_data_end),
        .fifo_full       (fifo_full),
        .outst_cnt       (outst_cnt),
        .rd_busy         (rd_busy),
        .rd_done         (rd_done),
        .ovf_err         (ovf_err)
`ifdef RD_CMD_STAT_EN
        ,
        .stat_cmd_cnt    (stat_cmd_cnt),
        .stat_stall_cnt  (stat_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: scoreboard pop on every accepted command, hold rule, in-flight model, completion.
    always @(negedge clk) begin
        if (rst) begin
            hold_pending = 1'b0;
        end else begin
            check("outst_cnt", 32'(outst_cnt), 32'(model_outst));
            check("app_cmd", 32'(app_cmd), 32'd1);
            if (hold_pending) begin
                check("hold_en", 32'(app_en), 32'd1);
                check("hold_addr", 32'(app_addr), 32'(hold_addr));
            end
            if (app_en && app_rdy) begin
                acc_cnt++;
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_cmd: issued 0x%0h, expected no command", app_addr);
                end else begin
                    exp_addr = sb.pop_front();
                    check("cmd_addr", 32'(app_addr), 32'(exp_addr));
                end
            end
            if (rd_done) begin
                done_cnt++;
                check("done_sb_empty", 32'(sb.size()), 32'd0);
                check("done_outst_zero", 32'(model_outst), 32'd0);
            end
            hold_pending = app_en && !app_rdy;
            hold_addr    = app_addr;
            if (app_rd_data_end && model_outst > 0) begin
                if (!(app_en && app_rdy)) model_outst--;
            end else if (app_en && app_rdy) begin
                model_outst++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (rand_mode) begin
            app_rdy         = ($urandom_range(0, 3) != 0);
            app_rd_data_end = (model_outst > 0) && ($urandom_range(0, 2) == 0);
        end
    endtask

    task automatic send(input logic [AW-1:0] a);
        int k = 0;
        while (fifo_full && k < 200) begin
            step();
            k++;
        end
        if (fifo_full) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: fifo_full stuck at 1, required 0");
        end else begin
            addr_in  = a;
            addr_vld = 1'b1;
            sb.push_back(a);
            step();
            addr_vld = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        addr_vld = 1'b0;
        read_stop = 1'b0;
        app_rdy = 1'b0;
        app_rd_data_end = 1'b0;
        rand_mode = 1'b0;
        step();
        step();
        sb.delete();
        model_outst = 0;
        rst = 1'b0;
        step();
    endtask

    // Raise read_stop, let random traffic drain everything, expect exactly one rd_done.
    task automatic finish_acq(input string nm);
        int exp_done;
        int k = 0;
        exp_done  = done_cnt + 1;
        read_stop = 1'b1;
        rand_mode = 1'b1;
        while (done_cnt < exp_done && k < 3000) begin
            step();
            k++;
        end
        rand_mode       = 1'b0;
        app_rdy         = 1'b1;
        app_rd_data_end = 1'b0;
        check({nm, "_done"}, 32'(done_cnt), 32'(exp_done));
        step();
        step();
        check({nm, "_idle"}, 32'(rd_busy), 32'd0);
        check({nm, "_done_once"}, 32'(done_cnt), 32'(exp_done));
    endtask

    initial begin
        int acc0;
        int d0;
        int k;
        bit [31:0] r;

        // Reset state
        step();
        step();
        rst = 1'b0;
        step();
        check("rst_app_en", 32'(app_en), 32'd0);
        check("rst_app_addr", 32'(app_addr), 32'd0);
        check("rst_fifo_full", 32'(fifo_full), 32'd0);
        check("rst_rd_busy", 32'(rd_busy), 32'd0);
        check("rst_rd_done", 32'(rd_done), 32'd0);
        check("rst_ovf_err", 32'(ovf_err), 32'd0);

        // T1 single command, N+2 latency, one-cycle app_en
        app_rdy = 1'b1;
        send(28'h0000040);
        check("t1_en_n1", 32'(app_en), 32'd0);
        step();
        check("t1_en_n2", 32'(app_en), 32'd1);
        check("t1_addr_n2", 32'(app_addr), 32'h40);
        step();
        check("t1_en_n3", 32'(app_en), 32'd0);
        for (int i = 0; i < 4; i++) step();
        app_rd_data_end = 1'b1;
        step();
        app_rd_data_end = 1'b0;
        check("t1_outst_back", 32'(outst_cnt), 32'd0);
        finish_acq("t1");

        // T2 backpressure then back-to-back issue
        do_reset();
        for (int i = 0; i < 8; i++) send(AW'(i * 8));
        step();
        step();
        check("t2_stall_en", 32'(app_en), 32'd1);
        check("t2_stall_addr", 32'(app_addr), 32'd0);
        acc0 = acc_cnt;
        app_rdy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("t2_consec_en", 32'(app_en), 32'd1);
            step();
        end
        check("t2_after_en", 32'(app_en), 32'd0);
        check("t2_acc", 32'(acc_cnt - acc0), 32'd8);
        check("t2_no_ovf", 32'(ovf_err), 32'd0);
        finish_acq("t2");

        // T3 overflow: 17 strobes with app_rdy low, only the first 16 kept
        do_reset();
        for (int i = 0; i < 17; i++) begin
            addr_in  = AW'(32'h1000 + i * 8);
            addr_vld = 1'b1;
            if (i < 16) sb.push_back(AW'(32'h1000 + i * 8));
            step();
            addr_vld = 1'b0;
            if (i == 14) check("t3_not_full_15", 32'(fifo_full), 32'd0);
            if (i == 15) begin
                check("t3_full_16", 32'(fifo_full), 32'd1);
                check("t3_no_ovf_16", 32'(ovf_err), 32'd0);
            end
            if (i == 16) check("t3_ovf_17", 32'(ovf_err), 32'd1);
        end
        app_rdy = 1'b1;
        finish_acq("t3");
        check("t3_ovf_sticky", 32'(ovf_err), 32'd1);

        // T4 outstanding cap
        do_reset();
        app_rdy = 1'b1;
        acc0 = acc_cnt;
        for (int i = 0; i < 40; i++) send(AW'(32'h20000 + i * 8));
        for (int i = 0; i < 10; i++) step();
        check("t4_acc_cap", 32'(acc_cnt - acc0), 32'd32);
        check("t4_outst_cap", 32'(outst_cnt), 32'd32);
        check("t4_en_low", 32'(app_en), 32'd0);
        app_rd_data_end = 1'b1;
        step();
        app_rd_data_end = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check("t4_release_one", 32'(acc_cnt - acc0), 32'd33);
        check("t4_outst_refill", 32'(outst_cnt), 32'd32);
        finish_acq("t4");

        // T5 accept and return in the same cycle, then read_stop during a backlog
        do_reset();
        app_rdy = 1'b1;
        for (int i = 0; i < 5; i++) send(AW'(32'h300 + i * 8));
        for (int i = 0; i < 5; i++) step();
        check("t5_outst5", 32'(outst_cnt), 32'd5);
        app_rdy = 1'b0;
        send(28'h0000500);
        k = 0;
        while (!app_en && k < 50) begin
            step();
            k++;
        end
        check("t5_presented", 32'(app_en), 32'd1);
        app_rdy = 1'b1;
        app_rd_data_end = 1'b1;
        step();
        app_rdy = 1'b0;
        app_rd_data_end = 1'b0;
        check("t5_simult_hold", 32'(outst_cnt), 32'd5);
        for (int i = 0; i < 6; i++) send(AW'(32'h600 + i * 8));
        read_stop = 1'b1;
        d0 = done_cnt;
        for (int i = 0; i < 10; i++) step();
        check("t5_busy_backlog", 32'(rd_busy), 32'd1);
        check("t5_no_early_done", 32'(done_cnt), 32'(d0));
        finish_acq("t5");

        // T6 reset in the middle of an operation
        do_reset();
        app_rdy = 1'b1;
        for (int i = 0; i < 3; i++) send(AW'(32'h700 + i * 8));
        for (int i = 0; i < 5; i++) step();
        check("t6_outst3", 32'(outst_cnt), 32'd3);
        app_rdy = 1'b0;
        for (int i = 0; i < 6; i++) send(AW'(32'h800 + i * 8));
        step();
        check("t6_pre_en", 32'(app_en), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("t6_rst_en", 32'(app_en), 32'd0);
        check("t6_rst_addr", 32'(app_addr), 32'd0);
        check("t6_rst_outst", 32'(outst_cnt), 32'd0);
        check("t6_rst_full", 32'(fifo_full), 32'd0);
        check("t6_rst_busy", 32'(rd_busy), 32'd0);
        check("t6_rst_ovf", 32'(ovf_err), 32'd0);
        step();
        sb.delete();
        model_outst = 0;
        rst = 1'b0;
        step();
        app_rdy = 1'b1;
        send(28'h0000100);
        check("t6_post_en_n1", 32'(app_en), 32'd0);
        step();
        check("t6_post_en_n2", 32'(app_en), 32'd1);
        check("t6_post_addr", 32'(app_addr), 32'h100);
        finish_acq("t6");

        // Randomized acquisitions back to back
        for (int a = 0; a < 3; a++) begin
            read_stop = 1'b0;
            rand_mode = 1'b1;
            k = $urandom_range(12, 40);
            for (int i = 0; i < k; i++) begin
                for (int g = $urandom_range(0, 2); g > 0; g--) step();
                r = $urandom();
                send({r[24:0], 3'b000});
            end
            finish_acq("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached before the summary");
        $fatal(1, "watchdog");
    end

endmodule
